seq_divider: RTL
================

# seq_divider

Multi-cycle restoring divider that undoes the ALU's multiply path. It takes an 8-bit dividend and a 4-bit divisor and produces an 8-bit quotient and a 4-bit remainder, one quotient bit per clock. It sits beside the ALU/accumulator datapath, takes operands from switches or the accumulator register, and drives results to LEDR/HEX. It uses a start/busy/done handshake.

## Interface
- No parameters; all widths are fixed.
- clk  input  1  system clock, rising-edge active.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request a division; sampled on the rising edge of clk.
- dividend  input  8  unsigned dividend; sampled only when start is accepted.
- divisor  input  4  unsigned divisor; sampled only when start is accepted.
- quotient  output  8  registered quotient of the last completed operation.
- remainder  output  4  registered remainder of the last completed operation.
- busy  output  1  high while in RUN.
- done  output  1  single-cycle pulse when a result becomes valid.
- div_by_zero  output  1  status of the last completed operation; high means its divisor was 0.

## Operation
- There is one clock domain. Reset is asynchronous and active-low.
- States:
  - IDLE: the reset state.
  - RUN: iterating; there are 8 iterations.
  - DONE: lasts exactly one cycle.
- Internal registers:
  - Q: 8-bit shift register.
  - R: 5-bit partial remainder.
  - D: 4-bit latched divisor.
  - cnt: 3-bit iteration counter.
- IDLE or DONE with start=1 (accept):
  - Latch D=divisor, Q=dividend, R=0, cnt=0.
  - If divisor==0, go to DONE.
  - Otherwise go to RUN.
- IDLE with start=0: stay in IDLE.
- DONE with start=0: go to IDLE.
- RUN, each cycle:
  - T = {R[3:0], Q[7]}.
  - If T >= {1'b0, D}: R = T - D and Q = {Q[6:0], 1}.
  - Otherwise: R = T and Q = {Q[6:0], 0}.
  - Then cnt = cnt + 1.
  - When cnt==7 on this cycle, go to DONE and load the outputs: quotient=Q(new), remainder=R(new)[3:0], div_by_zero=0.
- Divide by zero: on entry to DONE, load quotient=8'hFF, remainder=4'hF, div_by_zero=1.
- Arithmetic rules:
  - Everything is unsigned.
  - R never exceeds D-1 after an iteration, so remainder fits in 4 bits.
  - The invariant quotient*divisor + remainder == dividend holds for divisor != 0.
- start while in RUN is ignored. It is not queued; the in-flight operation and its operands are unaffected.
- Operand inputs may change freely after the accept edge.
- Outputs quotient, remainder and div_by_zero change only on entry to DONE. They hold their value otherwise, including across IDLE.

## Timing
- Reset (reset_n=0, takes effect immediately without a clock edge) clears:
  - state to IDLE;
  - quotient, remainder, busy, done and div_by_zero to 0;
  - Q, R, D and cnt to 0.
- Reset asserted mid-RUN aborts the operation. No done is produced and the outputs read 0.
- Normal latency, with edge 0 the accept edge:
  - busy=1 after edges 0 through 7, which is 8 cycles.
  - Edge 8 enters DONE.
  - done=1 and busy=0 for the one cycle after edge 8.
  - Results are valid in that same cycle.
- Divide-by-zero latency: done=1 in the cycle right after the accept edge; busy never rises.
- Back-to-back operation: start held high through the DONE cycle is accepted at edge 9. done then falls and busy rises at that edge, so throughput is one result per 9 cycles.
- done and busy are never high together.
- done is high for exactly one cycle per accepted operation.

## Test plan
- Reset, then dividend=200, divisor=7, single start pulse.
  - Required: busy high for 8 cycles, then done pulse, quotient=28, remainder=4, div_by_zero=0.
- Boundary values, run separately.
  - dividend=255, divisor=1 -> quotient=255, remainder=0.
  - dividend=255, divisor=15 -> quotient=17, remainder=0.
  - dividend=3, divisor=9 -> quotient=0, remainder=3.
- dividend=15, divisor=0.
  - Required: done one cycle after accept, busy stays 0, quotient=8'hFF, remainder=4'hF, div_by_zero=1.
  - Follow with 100/10: quotient=10, remainder=0, div_by_zero=0.
- Start 200/7; at RUN cycle 3 pulse start with 50/5.
  - Required: the second start is ignored, result is 28/4, and exactly one done pulse occurs.
- Start 200/7; drop reset_n asynchronously between edges at RUN cycle 4.
  - Required: all outputs 0 immediately, no done pulse.
  - After release, 9/2 -> quotient=4, remainder=1.
- Hold start=1 continuously with operands 77/6, then change operands to 64/8 just after the first accept.
  - Required: first done with quotient=12, remainder=5; second done 9 cycles later with quotient=8, remainder=0.

Source files
------------

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//
// Multi-cycle unsigned restoring divider: 8-bit dividend / 4-bit divisor gives
// an 8-bit quotient and a 4-bit remainder, resolving one quotient bit per clock
// (8 iterations). Operands are captured when start is accepted; results are
// registered and only change when the DONE state is entered.
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   start        request a division (accepted in IDLE or DONE)
//   dividend     8-bit unsigned dividend, sampled on accept
//   divisor      4-bit unsigned divisor, sampled on accept
//   quotient     registered quotient of the last completed operation
//   remainder    registered remainder of the last completed operation
//   busy         high while iterating
//   done         one-cycle pulse when a new result is valid
//   div_by_zero  high when the last completed operation had divisor 0
// -----------------------------------------------------------------------------
module seq_divider (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] dividend,
    input  logic [3:0] divisor,
    output logic [7:0] quotient,
    output logic [3:0] remainder,
    output logic       busy,
    output logic       done,
    output logic       div_by_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_reg;
    state_t      state_next;

    logic [7:0]  q_reg;        // dividend shifts out, quotient bits shift in
    logic [4:0]  r_reg;        // partial remainder
    logic [3:0]  d_reg;        // latched divisor
    logic [2:0]  cnt_reg;      // iteration counter

    logic [7:0]  quotient_reg;
    logic [3:0]  remainder_reg;
    logic        div_by_zero_reg;

    logic        accept;
    logic        last_iter;
    logic [4:0]  trial;
    logic        fits;
    logic [4:0]  r_step;
    logic [7:0]  q_step;

    // Start is only honoured when no operation is in flight.
    assign accept    = start && ((state_reg == S_IDLE) || (state_reg == S_DONE));
    assign last_iter = (cnt_reg == 3'd7);

    // One restoring step: bring down the next dividend bit and try a subtract.
    assign trial  = {r_reg[3:0], q_reg[7]};
    assign fits   = (trial >= {1'b0, d_reg});
    assign r_step = fits ? (trial - {1'b0, d_reg}) : trial;
    assign q_step = {q_reg[6:0], fits};

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    // A zero divisor skips the iterations entirely.
                    state_next = (divisor == 4'd0) ? S_DONE : S_RUN;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_RUN: begin
                if (last_iter) begin
                    state_next = S_DONE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_reg)
            S_RUN:   busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Datapath and result registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_reg           <= 8'd0;
            r_reg           <= 5'd0;
            d_reg           <= 4'd0;
            cnt_reg         <= 3'd0;
            quotient_reg    <= 8'd0;
            remainder_reg   <= 4'd0;
            div_by_zero_reg <= 1'b0;
        end else if (accept) begin
            q_reg   <= dividend;
            r_reg   <= 5'd0;
            d_reg   <= divisor;
            cnt_reg <= 3'd0;
            if (divisor == 4'd0) begin
                // Entering DONE directly: publish the saturated error result.
                quotient_reg    <= 8'hFF;
                remainder_reg   <= 4'hF;
                div_by_zero_reg <= 1'b1;
            end
        end else if (state_reg == S_RUN) begin
            q_reg   <= q_step;
            r_reg   <= r_step;
            cnt_reg <= cnt_reg + 3'd1;
            if (last_iter) begin
                quotient_reg    <= q_step;
                remainder_reg   <= r_step[3:0];
                div_by_zero_reg <= 1'b0;
            end
        end
    end

    assign quotient    = quotient_reg;
    assign remainder   = remainder_reg;
    assign div_by_zero = div_by_zero_reg;

endmodule
